// File: rtl/sdram_write_feeder.sv
// ---------------------------------------------------------------------------
// sdram_write_feeder: host write FIFO and run control for the SDRAM write engine
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sdram_write_feeder #(
  parameter int DEPTH_LOG2   = 4,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_stb,
  input  logic [21:0]           wr_addr,
  input  logic [31:0]           wr_data,
  input  logic [3:0]            wr_sel,
  output logic                  wr_ack,
  output logic                  wr_busy,
  output logic                  en,
  output logic [21:0]           address,
  input  logic                  ready,
  output logic [35:0]           fifo_data,
  output logic                  fifo_empty,
  input  logic                  fifo_rd,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int TW    = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state, state_next;
  logic [35:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [21:0]           next_addr;
  logic [TW-1:0]         idle_cnt, cnt_next;
  logic [DEPTH_LOG2:0]   level_next;
  logic                  pop, space, addr_ok, accept, en_next;

  // Level MSB set means every slot is occupied.
  assign pop     = fifo_rd && (level != '0);
  assign space   = !level[DEPTH_LOG2] || pop;
  assign accept  = wr_stb && space && addr_ok;
  assign wr_busy = wr_stb && !accept;

  always_comb begin
    addr_ok    = 1'b0;
    state_next = state;
    en_next    = en;
    cnt_next   = '0;
    case (state)
      IDLE: begin
        addr_ok = ready;
        if (accept) begin
          en_next    = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        addr_ok = (wr_addr == next_addr);
        if (wr_stb && !addr_ok) begin
          state_next = DRAIN;
        end else if (level != '0 || wr_stb) begin
          cnt_next = '0;
        end else if (idle_cnt == TW'(IDLE_TIMEOUT - 1)) begin
          state_next = DRAIN;
        end else begin
          cnt_next = idle_cnt + 1'b1;
        end
      end
      DRAIN: begin
        if (level == '0) en_next = 1'b0;
        if (!en && ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    case ({accept, pop})
      2'b10:   level_next = level + 1'b1;
      2'b01:   level_next = level - 1'b1;
      default: level_next = level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      en         <= 1'b0;
      address    <= '0;
      next_addr  <= '0;
      idle_cnt   <= '0;
      wr_ack     <= 1'b0;
      level      <= '0;
      fifo_empty <= 1'b1;
      fifo_data  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      state      <= state_next;
      en         <= en_next;
      idle_cnt   <= cnt_next;
      wr_ack     <= accept;
      level      <= level_next;
      fifo_empty <= (level_next == '0);
      if (accept) begin
        wr_ptr    <= wr_ptr + 1'b1;
        next_addr <= wr_addr + 22'd2;
        if (state == IDLE) address <= wr_addr;
      end
      if (pop) begin
        fifo_data <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 1'b1;
      end
    end
  end

  // Storage needs no reset: pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (accept && !rst) mem[wr_ptr] <= {~wr_sel, wr_data};
  end

endmodule

`default_nettype wire

// File: tb/tb_sdram_write_feeder.sv
// ---------------------------------------------------------------------------
// tb_sdram_write_feeder: directed vector table plus multi-cycle corner sequences
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sdram_write_feeder;

  localparam int DEPTH_LOG2   = 4;
  localparam int IDLE_TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst, wr_stb, wr_ack, wr_busy, en, ready, fifo_empty, fifo_rd;
  logic [21:0] wr_addr, address;
  logic [31:0] wr_data;
  logic [3:0]  wr_sel;
  logic [35:0] fifo_data;
  logic [4:0]  level;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sdram_write_feeder #(.DEPTH_LOG2(DEPTH_LOG2), .IDLE_TIMEOUT(IDLE_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_sel(wr_sel), .wr_ack(wr_ack), .wr_busy(wr_busy), .en(en), .address(address),
    .ready(ready), .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
    .level(level)
  );

  // Inputs for one cycle; busy is the combinational value that cycle,
  // the remaining fields are the registered outputs after the edge.
  typedef struct {
    logic        rst;
    logic        stb;
    logic [21:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    logic        rd;
    logic        rdy;
    logic        busy;
    logic        ack;
    logic        en;
    logic [21:0] address;
    logic [4:0]  level;
    logic        empty;
    logic [35:0] fdata;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0]  s;
    logic [31:0] d;

    //            rst  stb  addr        data           sel   rd   rdy  busy ack  en   address     lvl   emp  fdata
    vecs[0]  = '{1'b1,1'b0,22'h000000,32'h0,         4'h0,1'b0,1'b1,1'b0,1'b0,1'b0,22'h000000,5'd0,1'b1,36'h0};
    vecs[1]  = '{1'b0,1'b1,22'h000100,32'h11111111,  4'hF,1'b0,1'b1,1'b0,1'b1,1'b1,22'h000100,5'd1,1'b0,36'h0};
    vecs[2]  = '{1'b0,1'b1,22'h000102,32'h22222222,  4'hF,1'b0,1'b1,1'b0,1'b1,1'b1,22'h000100,5'd2,1'b0,36'h0};
    vecs[3]  = '{1'b0,1'b1,22'h000104,32'h33333333,  4'hF,1'b0,1'b1,1'b0,1'b1,1'b1,22'h000100,5'd3,1'b0,36'h0};
    vecs[4]  = '{1'b0,1'b0,22'h000000,32'h0,         4'h0,1'b1,1'b1,1'b0,1'b0,1'b1,22'h000100,5'd2,1'b0,36'h0_11111111};
    vecs[5]  = '{1'b0,1'b0,22'h000000,32'h0,         4'h0,1'b1,1'b1,1'b0,1'b0,1'b1,22'h000100,5'd1,1'b0,36'h0_22222222};
    vecs[6]  = '{1'b0,1'b0,22'h000000,32'h0,         4'h0,1'b1,1'b1,1'b0,1'b0,1'b1,22'h000100,5'd0,1'b1,36'h0_33333333};
    vecs[7]  = '{1'b0,1'b0,22'h000000,32'h0,         4'h0,1'b1,1'b1,1'b0,1'b0,1'b1,22'h000100,5'd0,1'b1,36'h0_33333333};
    vecs[8]  = '{1'b1,1'b0,22'h000000,32'h0,         4'h0,1'b0,1'b1,1'b0,1'b0,1'b0,22'h000000,5'd0,1'b1,36'h0};
    vecs[9]  = '{1'b0,1'b1,22'h000200,32'hAAAA0200,  4'h5,1'b0,1'b1,1'b0,1'b1,1'b1,22'h000200,5'd1,1'b0,36'h0};
    vecs[10] = '{1'b0,1'b1,22'h000400,32'hBBBB0400,  4'hF,1'b0,1'b1,1'b1,1'b0,1'b1,22'h000200,5'd1,1'b0,36'h0};
    vecs[11] = '{1'b0,1'b1,22'h000400,32'hBBBB0400,  4'hF,1'b1,1'b1,1'b1,1'b0,1'b1,22'h000200,5'd0,1'b1,36'hA_AAAA0200};
    vecs[12] = '{1'b0,1'b1,22'h000400,32'hBBBB0400,  4'hF,1'b0,1'b1,1'b1,1'b0,1'b0,22'h000200,5'd0,1'b1,36'hA_AAAA0200};
    vecs[13] = '{1'b0,1'b1,22'h000400,32'hBBBB0400,  4'hF,1'b0,1'b1,1'b1,1'b0,1'b0,22'h000200,5'd0,1'b1,36'hA_AAAA0200};
    vecs[14] = '{1'b0,1'b1,22'h000400,32'hBBBB0400,  4'hF,1'b0,1'b1,1'b0,1'b1,1'b1,22'h000400,5'd1,1'b0,36'hA_AAAA0200};
    vecs[15] = '{1'b0,1'b0,22'h000000,32'h0,         4'h0,1'b1,1'b1,1'b0,1'b0,1'b1,22'h000400,5'd0,1'b1,36'h0_BBBB0400};
    vecs[16] = '{1'b0,1'b0,22'h000000,32'h0,         4'h0,1'b1,1'b1,1'b0,1'b0,1'b1,22'h000400,5'd0,1'b1,36'h0_BBBB0400};

    for (int i = 0; i < NV; i++) begin
      rst = vecs[i].rst; wr_stb = vecs[i].stb; wr_addr = vecs[i].addr; wr_data = vecs[i].data;
      wr_sel = vecs[i].sel; fifo_rd = vecs[i].rd; ready = vecs[i].rdy;
      #1;
      check($sformatf("v%0d busy", i), 64'(wr_busy), 64'(vecs[i].busy));
      tick();
      check($sformatf("v%0d ack", i), 64'(wr_ack), 64'(vecs[i].ack));
      check($sformatf("v%0d en", i), 64'(en), 64'(vecs[i].en));
      check($sformatf("v%0d address", i), 64'(address), 64'(vecs[i].address));
      check($sformatf("v%0d level", i), 64'(level), 64'(vecs[i].level));
      check($sformatf("v%0d empty", i), 64'(fifo_empty), 64'(vecs[i].empty));
      check($sformatf("v%0d fifo_data", i), 64'(fifo_data), 64'(vecs[i].fdata));
    end

    // Idle timeout: the last vector was the first empty, strobe-free cycle in RUN.
    fifo_rd = 1'b0;
    repeat (IDLE_TIMEOUT - 1) tick();
    check("timeout en before drop", 64'(en), 64'd1);
    tick();
    check("timeout en dropped", 64'(en), 64'd0);
    tick();

    // Fill all 16 entries from IDLE with a contiguous run, no pops.
    for (int i = 0; i < 16; i++) begin
      wr_stb = 1'b1; wr_addr = 22'h000300 + 22'(2 * i);
      wr_data = 32'hC0DE0000 + 32'(i); wr_sel = 4'(i);
      #1;
      check($sformatf("fill%0d busy", i), 64'(wr_busy), 64'd0);
      tick();
      check($sformatf("fill%0d ack", i), 64'(wr_ack), 64'd1);
    end
    check("full level", 64'(level), 64'd16);
    check("full empty", 64'(fifo_empty), 64'd0);
    check("full address", 64'(address), 64'h000300);

    wr_addr = 22'h000320; wr_data = 32'hC0DE0010; wr_sel = 4'h0;
    #1;
    check("full stall busy", 64'(wr_busy), 64'd1);
    tick();
    check("full stall ack", 64'(wr_ack), 64'd0);
    check("full stall level", 64'(level), 64'd16);
    fifo_rd = 1'b1;
    #1;
    check("full pop busy", 64'(wr_busy), 64'd0);
    tick();
    check("full pop ack", 64'(wr_ack), 64'd1);
    check("full pop level", 64'(level), 64'd16);
    check("full pop data", 64'(fifo_data), 64'({4'hF, 32'hC0DE0000}));

    wr_stb = 1'b0;
    for (int j = 1; j <= 11; j++) begin
      tick();
      s = ~4'(j);
      d = 32'hC0DE0000 + 32'(j);
      check($sformatf("drain pop%0d data", j), 64'(fifo_data), 64'({s, d}));
    end
    fifo_rd = 1'b0;
    check("pre-reset level", 64'(level), 64'd5);

    // Reset mid-run with entries pending.
    rst = 1'b1;
    tick();
    check("mid rst level", 64'(level), 64'd0);
    check("mid rst en", 64'(en), 64'd0);
    check("mid rst empty", 64'(fifo_empty), 64'd1);
    check("mid rst fifo_data", 64'(fifo_data), 64'd0);
    rst = 1'b0;
    tick();
    check("post rst level", 64'(level), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
